axis_packet_integrity_monitor: RTL and testbench

//  Synthesisable, passive AXI-Stream tap checking packet integrity per TDEST channel in-line.

---
 rtl/axis_packet_integrity_monitor.sv | 221 ++++++++++++++++++++++
 tb/tb_axis_packet_integrity_monitor.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axis_packet_integrity_monitor.sv
// Passive AXI-Stream tap: per-TDEST packet length, TKEEP and sequence-number checks with stat counters.
// Define AXIS_PKT_MON_TIMEOUT_EN to abort packets left open with no beats for TIMEOUT_CYCLES cycles.

module axis_pim_chan #(
    parameter int DATA_BYTES = 8,
    parameter int MTU_BYTES  = 1500,
    parameter int MIN_BYTES  = 64,
    parameter int CNT_WIDTH  = 32,
    parameter int LEN_W      = $clog2(MTU_BYTES + 2),
    parameter int POP_W      = $clog2(DATA_BYTES + 1)
) (
    input  logic                 clk,
    input  logic                 sreset,
    input  logic                 hit,
    input  logic                 last,
    input  logic                 keep_bad_beat,
    input  logic                 clear,
    input  logic                 abort,
    input  logic [POP_W-1:0]     pop,
    input  logic [15:0]          seq,
    output logic                 in_pkt,
    output logic [LEN_W-1:0]     byte_cnt,
    output logic [LEN_W-1:0]     close_len,
    output logic [3:0]           close_err,
    output logic [CNT_WIDTH-1:0] pkt_cnt,
    output logic [CNT_WIDTH-1:0] err_cnt
);
    localparam int SAT = MTU_BYTES + 1;

    logic        keep_bad, seq_bad;
    logic [15:0] exp_seq;
    logic        opening, seq_chk, kb_now, sb_now, closing, aborting;
    logic [31:0] sum;

    always_comb begin
        opening  = hit & ~in_pkt;
        // a 0/1-byte single-beat packet carries no sequence number
        seq_chk  = opening & ~(last & (32'(pop) < 32'd2));
        kb_now   = (~opening & keep_bad) | keep_bad_beat;
        sb_now   = (~opening & seq_bad) | (seq_chk & (seq != exp_seq));
        sum      = (opening ? 32'd0 : 32'(byte_cnt)) + 32'(pop);
        close_len = (sum > 32'(SAT)) ? LEN_W'(SAT) : LEN_W'(sum);
        if (32'(close_len) < 32'd2)
            close_err = 4'b0001;
        else
            close_err = {kb_now, sb_now, 32'(close_len) > 32'(MTU_BYTES),
                         32'(close_len) < 32'(MIN_BYTES)};
        closing  = hit & last;
        aborting = abort & in_pkt;
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            in_pkt   <= 1'b0;
            byte_cnt <= '0;
            keep_bad <= 1'b0;
            seq_bad  <= 1'b0;
            exp_seq  <= '0;
            pkt_cnt  <= '0;
            err_cnt  <= '0;
        end else begin
            if (abort) begin
                in_pkt   <= 1'b0;
                byte_cnt <= '0;
                keep_bad <= 1'b0;
                seq_bad  <= 1'b0;
            end else if (hit) begin
                in_pkt   <= ~last;
                byte_cnt <= last ? '0 : close_len;
                keep_bad <= ~last & kb_now;
                seq_bad  <= ~last & sb_now;
            end
            if (clear)        exp_seq <= '0;
            else if (seq_chk) exp_seq <= seq + 16'd1;
            if (clear)
                pkt_cnt <= '0;
            else if (closing && pkt_cnt != '1)
                pkt_cnt <= pkt_cnt + CNT_WIDTH'(1);
            if (clear)
                err_cnt <= '0;
            else if (((closing && close_err != 4'd0) || aborting) && err_cnt != '1)
                err_cnt <= err_cnt + CNT_WIDTH'(1);
        end
    end
endmodule

module axis_packet_integrity_monitor #(
    parameter int DATA_BYTES     = 8,
    parameter int NUM_DESTS      = 4,
    parameter int DEST_WIDTH     = (NUM_DESTS > 1) ? $clog2(NUM_DESTS) : 1,
    parameter int MTU_BYTES      = 1500,
    parameter int MIN_BYTES      = 64,
    parameter int CNT_WIDTH      = 32,
    parameter int TIMEOUT_CYCLES = 1024
) (
    input  logic                               clk,
    input  logic                               sreset,
    input  logic                               s_tvalid,
    input  logic                               s_tready,
    input  logic [DATA_BYTES*8-1:0]            s_tdata,
    input  logic [DATA_BYTES-1:0]              s_tkeep,
    input  logic                               s_tlast,
    input  logic [DEST_WIDTH-1:0]              s_tdest,
    input  logic                               stat_clear,
    input  logic [DEST_WIDTH-1:0]              stat_dest,
    output logic [CNT_WIDTH-1:0]               stat_pkt_cnt,
    output logic [CNT_WIDTH-1:0]               stat_err_cnt,
    output logic                               done_valid,
    output logic [DEST_WIDTH-1:0]              done_dest,
    output logic [$clog2(MTU_BYTES+2)-1:0]     done_len,
    output logic [5:0]                         done_err
);
    localparam int LEN_W = $clog2(MTU_BYTES + 2);
    localparam int POP_W = $clog2(DATA_BYTES + 1);

    logic                                 beat, dest_ok, contig, keep_bad_beat, abort;
    logic [POP_W-1:0]                     pop;
    logic [NUM_DESTS-1:0]                 hit, in_pkt;
    logic [NUM_DESTS-1:0][LEN_W-1:0]      byte_cnt, close_len;
    logic [NUM_DESTS-1:0][3:0]            close_err;
    logic [NUM_DESTS-1:0][CNT_WIDTH-1:0]  pkt_cnt, err_cnt;
    logic [LEN_W-1:0]                     sel_len, ab_len;
    logic [3:0]                           sel_err;
    logic [DEST_WIDTH-1:0]                ab_dest;
    logic [CNT_WIDTH-1:0]                 sel_pkt_cnt, sel_err_cnt;

    wire unused_data = ^s_tdata;

    always_comb begin
        beat    = s_tvalid & s_tready;
        dest_ok = 32'(s_tdest) < 32'(NUM_DESTS);
        pop     = '0;
        for (int i = 0; i < DATA_BYTES; i++)
            pop = pop + POP_W'(s_tkeep[i]);
        // LSB-contiguous (incl. all-zero and all-ones) iff keep & (keep+1) == 0
        contig        = (s_tkeep & (s_tkeep + DATA_BYTES'(1))) == '0;
        keep_bad_beat = s_tlast ? ~contig : (s_tkeep != '1);
        for (int d = 0; d < NUM_DESTS; d++)
            hit[d] = beat & (s_tdest == DEST_WIDTH'(d));
    end

    for (genvar g = 0; g < NUM_DESTS; g++) begin : g_chan
        axis_pim_chan #(
            .DATA_BYTES(DATA_BYTES), .MTU_BYTES(MTU_BYTES), .MIN_BYTES(MIN_BYTES),
            .CNT_WIDTH(CNT_WIDTH), .LEN_W(LEN_W), .POP_W(POP_W)
        ) u_chan (
            .clk(clk), .sreset(sreset), .hit(hit[g]), .last(s_tlast),
            .keep_bad_beat(keep_bad_beat), .clear(stat_clear), .abort(abort),
            .pop(pop), .seq({s_tdata[7:0], s_tdata[15:8]}),
            .in_pkt(in_pkt[g]), .byte_cnt(byte_cnt[g]), .close_len(close_len[g]),
            .close_err(close_err[g]), .pkt_cnt(pkt_cnt[g]), .err_cnt(err_cnt[g])
        );
    end

`ifdef AXIS_PKT_MON_TIMEOUT_EN
    localparam int IDLE_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [IDLE_W-1:0] idle_cnt;

    // fires on the TIMEOUT_CYCLES-th consecutive beat-less cycle with a packet open
    assign abort = ~beat & (|in_pkt) & (32'(idle_cnt) == 32'(TIMEOUT_CYCLES - 1));

    always_ff @(posedge clk) begin
        if (sreset || beat || !(|in_pkt) || abort) idle_cnt <= '0;
        else                                       idle_cnt <= idle_cnt + IDLE_W'(1);
    end
`else
    assign abort = 1'b0;
    wire unused_timeout = (TIMEOUT_CYCLES > 0);
`endif

    always_comb begin
        sel_len     = '0;
        sel_err     = '0;
        ab_dest     = '0;
        ab_len      = '0;
        sel_pkt_cnt = '0;
        sel_err_cnt = '0;
        for (int d = 0; d < NUM_DESTS; d++) begin
            if (hit[d]) begin
                sel_len = close_len[d];
                sel_err = close_err[d];
            end
            if (stat_dest == DEST_WIDTH'(d)) begin
                sel_pkt_cnt = pkt_cnt[d];
                sel_err_cnt = err_cnt[d];
            end
        end
        for (int d = NUM_DESTS - 1; d >= 0; d--) begin
            if (in_pkt[d]) begin
                ab_dest = DEST_WIDTH'(d);
                ab_len  = byte_cnt[d];
            end
        end
    end

    always_ff @(posedge clk) begin
        if (sreset) begin
            done_valid   <= 1'b0;
            done_dest    <= '0;
            done_len     <= '0;
            done_err     <= '0;
            stat_pkt_cnt <= '0;
            stat_err_cnt <= '0;
        end else begin
            done_valid   <= 1'b0;
            stat_pkt_cnt <= sel_pkt_cnt;
            stat_err_cnt <= sel_err_cnt;
            if (beat && s_tlast) begin
                done_valid <= 1'b1;
                done_dest  <= s_tdest;
                done_len   <= dest_ok ? sel_len : '0;
                done_err   <= dest_ok ? {2'b00, sel_err} : 6'b010000;
            end else if (abort) begin
                done_valid <= 1'b1;
                done_dest  <= ab_dest;
                done_len   <= ab_len;
                done_err   <= 6'b100000;
            end
        end
    end
endmodule

// File: tb/tb_axis_packet_integrity_monitor.sv
// Bench for axis_packet_integrity_monitor: vector table, directed corner sequences, random vs packet model.

module tb_axis_packet_integrity_monitor;
    localparam int DB = 8, ND = 4, DW = 3, MTU = 1500, MINB = 64, CW = 32, TO = 16, LW = 11;

    logic          clk = 1'b0, sreset = 1'b1;
    logic          s_tvalid = 1'b0, s_tready = 1'b0, s_tlast = 1'b0, stat_clear = 1'b0;
    logic [63:0]   s_tdata = '0;
    logic [7:0]    s_tkeep = '0;
    logic [DW-1:0] s_tdest = '0, stat_dest = '0;
    logic [CW-1:0] stat_pkt_cnt, stat_err_cnt;
    logic          done_valid;
    logic [DW-1:0] done_dest;
    logic [LW-1:0] done_len;
    logic [5:0]    done_err;

    int checks = 0, errors = 0;
    bit use_model = 0;

    typedef struct { logic [DW-1:0] dest; int len; logic [5:0] err; } done_t;
    typedef struct { int dest; int seq; int len; bit midbad; int exp_len; logic [5:0] exp_err; } vec_t;
    done_t got_q[$], exp_q[$];
    vec_t  tbl[17];

    bit          m_open[ND], m_kb[ND], m_sb[ND];
    int          m_len[ND], m_pkt[ND], m_err[ND];
    logic [15:0] m_exp[ND];

    axis_packet_integrity_monitor #(
        .DATA_BYTES(DB), .NUM_DESTS(ND), .DEST_WIDTH(DW), .MTU_BYTES(MTU),
        .MIN_BYTES(MINB), .CNT_WIDTH(CW), .TIMEOUT_CYCLES(TO)
    ) dut (
        .clk(clk), .sreset(sreset), .s_tvalid(s_tvalid), .s_tready(s_tready),
        .s_tdata(s_tdata), .s_tkeep(s_tkeep), .s_tlast(s_tlast), .s_tdest(s_tdest),
        .stat_clear(stat_clear), .stat_dest(stat_dest), .stat_pkt_cnt(stat_pkt_cnt),
        .stat_err_cnt(stat_err_cnt), .done_valid(done_valid), .done_dest(done_dest),
        .done_len(done_len), .done_err(done_err)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input longint got, input longint exp);
        checks++;
        if (got != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, got, exp);
        end
    endtask

    always @(negedge clk) begin
        if (done_valid === 1'b1) begin
            done_t r, e;
            r.dest = done_dest; r.len = int'(done_len); r.err = done_err;
            if (!use_model) got_q.push_back(r);
            else if (exp_q.size() == 0) begin
                checks++; errors++;
                $display("FAIL rnd_unexpected_done: got dest %0d err %0d expected no pulse", r.dest, r.err);
            end else begin
                e = exp_q.pop_front();
                chk("rnd_dest", r.dest, e.dest);
                chk("rnd_len", r.len, e.len);
                chk("rnd_err", r.err, e.err);
            end
        end
    end

    // packet-level reference: accumulate per-dest, judge the whole packet at tlast
    task automatic model_beat(input int d, input logic [63:0] data, input logic [7:0] keep, input bit last);
        int n; done_t e; logic [15:0] sq;
        n = $countones(keep);
        if (d >= ND) begin
            if (last) begin e.dest = DW'(d); e.len = 0; e.err = 6'h10; exp_q.push_back(e); end
            return;
        end
        if (!m_open[d]) begin
            m_open[d] = 1; m_len[d] = 0; m_kb[d] = 0; m_sb[d] = 0;
            sq = {data[7:0], data[15:8]};
            if (!(last && n < 2)) begin m_sb[d] = (sq != m_exp[d]); m_exp[d] = sq + 16'd1; end
        end
        m_len[d] += n;
        if (last ? (keep != 8'((1 << n) - 1)) : (keep != 8'hFF)) m_kb[d] = 1;
        if (last) begin
            e.dest = DW'(d);
            e.len  = (m_len[d] > MTU + 1) ? MTU + 1 : m_len[d];
            e.err  = (m_len[d] < 2) ? 6'h01 : {2'b00, m_kb[d], m_sb[d], m_len[d] > MTU, m_len[d] < MINB};
            exp_q.push_back(e);
            m_pkt[d]++;
            if (e.err != 0) m_err[d]++;
            m_open[d] = 0;
        end
    endtask

    task automatic beat(input int d, input logic [63:0] data, input logic [7:0] keep, input bit last, input bit rdy);
        @(negedge clk);
        s_tvalid = 1'b1; s_tready = rdy; s_tdata = data; s_tkeep = keep; s_tlast = last; s_tdest = DW'(d);
        if (rdy && use_model) model_beat(d, data, keep, last);
    endtask

    task automatic idle(input int n);
        repeat (n) begin
            @(negedge clk);
            s_tvalid = 1'b0; s_tready = 1'($urandom); s_tlast = 1'($urandom);
        end
    endtask

    function automatic logic [7:0] keep_for(input int rem);
        logic [8:0] t;
        if (rem >= 8) return 8'hFF;
        t = (9'd1 << rem) - 9'd1;
        return t[7:0];
    endfunction

    function automatic logic [63:0] mkdata(input bit first, input logic [15:0] seq);
        logic [63:0] v;
        v = {$urandom, $urandom};
        if (first) v[15:0] = {seq[7:0], seq[15:8]};
        return v;
    endfunction

    task automatic send_pkt(input int d, input int seq, input int len, input bit midbad);
        int nb; logic [7:0] k;
        nb = (len + 7) / 8;
        for (int i = 0; i < nb; i++) begin
            k = keep_for(len - 8 * i);
            if (midbad && i == 1 && i != nb - 1) k = 8'h7F;
            beat(d, mkdata(i == 0, 16'(seq)), k, i == nb - 1, 1'b1);
        end
    endtask

    task automatic expect_done(input string name, input int dest, input int len, input logic [5:0] err);
        int t; done_t r;
        t = 0;
        while (got_q.size() == 0 && t < 50) begin @(negedge clk); t++; end
        if (got_q.size() == 0) begin
            checks++; errors++;
            $display("FAIL %s: no done pulse, expected dest %0d len %0d err %0d", name, dest, len, err);
        end else begin
            r = got_q.pop_front();
            chk({name, "_dest"}, r.dest, dest);
            chk({name, "_len"}, r.len, len);
            chk({name, "_err"}, r.err, err);
        end
    endtask

    task automatic chk_stat(input string name, input int d, input int pkt, input int err);
        @(negedge clk); stat_dest = DW'(d);
        @(negedge clk);
        chk({name, "_pkt_cnt"}, stat_pkt_cnt, pkt);
        chk({name, "_err_cnt"}, stat_err_cnt, err);
    endtask

    bit          s_act[5], s_first[5];
    int          s_rem[5];
    logic [15:0] s_seq[5];

    initial begin
        for (int i = 0; i < 4; i++) tbl[i] = '{0, i, 64, 0, 64, 6'h00};
        tbl[4]  = '{1, 0, 64, 0, 64, 6'h00};
        tbl[5]  = '{1, 1, 72, 0, 72, 6'h00};
        tbl[6]  = '{1, 5, 64, 0, 64, 6'h04};
        tbl[7]  = '{1, 6, 100, 0, 100, 6'h00};
        tbl[8]  = '{2, 0, 63, 0, 63, 6'h01};
        tbl[9]  = '{2, 1, 1501, 0, 1501, 6'h02};
        tbl[10] = '{2, 2, 1600, 0, 1501, 6'h02};
        tbl[11] = '{3, 0, 80, 1, 79, 6'h08};
        tbl[12] = '{3, 9, 1, 0, 1, 6'h01};
        tbl[13] = '{3, 1, 8, 0, 8, 6'h01};
        tbl[14] = '{3, 2, 64, 0, 64, 6'h00};
        tbl[15] = '{5, 0, 16, 0, 0, 6'h10};
        tbl[16] = '{3, 3, 64, 0, 64, 6'h00};

        repeat (3) @(negedge clk);
        chk("reset_done_valid", done_valid, 0);
        chk("reset_pkt_cnt", stat_pkt_cnt, 0);
        chk("reset_err_cnt", stat_err_cnt, 0);
        sreset = 1'b0;

        for (int i = 0; i < 17; i++) begin
            send_pkt(tbl[i].dest, tbl[i].seq, tbl[i].len, tbl[i].midbad);
            idle(2);
            expect_done($sformatf("vec%0d", i), tbl[i].dest, tbl[i].exp_len, tbl[i].exp_err);
        end
        chk_stat("tbl_d0", 0, 4, 0);
        chk_stat("tbl_d1", 1, 4, 1);
        chk_stat("tbl_d2", 2, 3, 3);
        chk_stat("tbl_d3", 3, 5, 3);
        chk_stat("tbl_d5", 5, 0, 0);

        // dest 2/3 interleaved, with junk stalled beats in between
        for (int i = 0; i < 9; i++) begin
            if (i < 8) beat(2, mkdata(i == 0, 16'd3), 8'hFF, i == 7, 1'b1);
            beat(3, 64'hDEAD_BEEF, 8'hAA, 1'b1, 1'b0);
            beat(3, mkdata(i == 0, 16'd4), (i == 8) ? 8'h3F : 8'hFF, i == 8, 1'b1);
        end
        idle(2);
        expect_done("ilv_d2", 2, 64, 6'h00);
        expect_done("ilv_d3", 3, 70, 6'h00);

        // clear coinciding with the closing increment
        beat(0, mkdata(1, 16'd4), 8'hFF, 1'b0, 1'b1);
        beat(0, mkdata(0, 16'd0), 8'hFF, 1'b1, 1'b1);
        stat_clear = 1'b1;
        @(negedge clk); stat_clear = 1'b0; s_tvalid = 1'b0;
        expect_done("clr_pkt", 0, 16, 6'h01);
        idle(2);
        chk_stat("clr_d0", 0, 0, 0);
        chk_stat("clr_d1", 1, 0, 0);
        send_pkt(0, 0, 64, 0);
        idle(2);
        expect_done("clr_seq0", 0, 64, 6'h00);
        chk_stat("clr_after", 0, 1, 0);

        // reset in the middle of a dest 0 packet
        for (int i = 0; i < 3; i++) beat(0, mkdata(i == 0, 16'd1), 8'hFF, 1'b0, 1'b1);
        @(negedge clk); s_tvalid = 1'b0; sreset = 1'b1;
        repeat (2) @(negedge clk);
        sreset = 1'b0;
        idle(3);
        chk("rst_no_pulse", got_q.size(), 0);
        send_pkt(0, 0, 64, 0);
        idle(2);
        expect_done("rst_seq0", 0, 64, 6'h00);
        chk_stat("rst_d0", 0, 1, 0);

`ifdef AXIS_PKT_MON_TIMEOUT_EN
        begin : to_blk
            int n; bit seen;
            n = 0; seen = 0;
            beat(1, mkdata(1, 16'd0), 8'hFF, 1'b0, 1'b1);
            beat(1, mkdata(0, 16'd0), 8'hFF, 1'b0, 1'b1);
            while (!seen && n < 40) begin
                @(negedge clk); s_tvalid = 1'b0; n++;
                if (done_valid === 1'b1) seen = 1;
            end
            chk("to_idle_cycles", n, 17);
            expect_done("to", 1, 16, 6'h20);
            idle(2);
            chk_stat("to_d1", 1, 0, 1);
        end
`endif

        // randomized interleaved traffic against the packet model
        @(negedge clk); sreset = 1'b1;
        repeat (2) @(negedge clk);
        sreset = 1'b0;
        got_q.delete();
        for (int d = 0; d < ND; d++) begin
            m_open[d] = 0; m_kb[d] = 0; m_sb[d] = 0; m_len[d] = 0; m_pkt[d] = 0; m_err[d] = 0; m_exp[d] = '0;
        end
        for (int d = 0; d < 5; d++) s_act[d] = 0;
        use_model = 1;
        for (int it = 0; it < 4000; it++) begin
            int d; logic [7:0] k; bit lst, rdy;
            d = $urandom_range(0, 4);
            if (!s_act[d]) begin
                s_act[d] = 1; s_first[d] = 1;
                s_rem[d] = ($urandom_range(0, 9) == 0) ? $urandom_range(1400, 1600) : $urandom_range(1, 150);
                s_seq[d] = 16'($urandom);
                if (d < ND && $urandom_range(0, 3) != 0) s_seq[d] = m_exp[d];
            end
            k = keep_for(s_rem[d]);
            if ($urandom_range(0, 39) == 0) k = 8'($urandom);
            lst = (s_rem[d] <= 8);
            rdy = ($urandom_range(0, 4) != 0);
            beat(d, mkdata(s_first[d], s_seq[d]), k, lst, rdy);
            if (rdy) begin
                s_first[d] = 0; s_rem[d] -= 8;
                if (lst) s_act[d] = 0;
            end
        end
        for (int d = 0; d < 5; d++) begin
            while (s_act[d]) begin
                beat(d, mkdata(s_first[d], s_seq[d]), keep_for(s_rem[d]), s_rem[d] <= 8, 1'b1);
                s_first[d] = 0;
                if (s_rem[d] <= 8) s_act[d] = 0;
                s_rem[d] -= 8;
            end
        end
        idle(4);
        chk("rnd_all_done", exp_q.size(), 0);
        for (int d = 0; d < ND; d++) chk_stat($sformatf("rnd_d%0d", d), d, m_pkt[d], m_err[d]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
